// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the serial shift stages that sit
// downstream of the barrel shifter.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_bit_cnt.sv
// Bit-position up-counter: clears to 0, advances on enable, and flags the
// terminal count TERM-1 without ever wrapping past it.
module shift_bit_cnt
    import shift_pkg::*;
#(
    parameter  int TERM = DEF_WIDTH,
    localparam int CW   = cnt_w(TERM)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !last_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CW'(TERM - 1));
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/piso_shift_out.sv
// Parallel-in/serial-out stage: captures a barrel-shifter word on a valid/ready
// handshake and streams it one bit per enabled clock, reloading with no gap.
module piso_shift_out
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    // Handshake: a word transfers on a rising edge where in_valid and in_ready
    // are both high; the source keeps in_data stable until that edge, and
    // in_valid while in_ready is low is simply not sampled.
    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic             init_q;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             accept;
    logic             advance;
    logic             frame_end;

    shift_bit_cnt #(
        .TERM (WIDTH)
    ) u_bit_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (accept),
        .en_i   (advance),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (frame_end && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready stays low until the first edge after reset release.
    always_comb begin
        in_ready    = init_q & ((state_q == IDLE) | ((state_q == SHIFT) & cnt_last & ser_en));
        accept      = in_valid & in_ready;
        ser_valid   = (state_q == SHIFT);
        busy        = (state_q == SHIFT);
        frame_end   = (state_q == SHIFT) & cnt_last & ser_en;
        advance     = (state_q == SHIFT) & ser_en & ~cnt_last;
        frame_done  = frame_end;
        frame_start = (state_q == SHIFT) & (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    // The bit on ser_out always sits at the outgoing end of the register.
    always_comb begin
        if (MSB_FIRST != 0) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        sreg_d = sreg_q;
        if (accept) begin
            sreg_d = in_data;
        end else if (advance) begin
            sreg_d = sreg_shifted;
        end else if (frame_end) begin
            sreg_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign ser_out = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule
